// File: rtl/haraka_round_sched.sv
// haraka_round_sched: time-shares one single-round, 1-cycle-latency AES unit
// across the LANES 128-bit lanes of a Haraka state. Accepts a state, runs
// NUM_ROUNDS x AES_PER_ROUND AES rounds per lane, then returns the state.
// Optional: define HARAKA_SCHED_MIX_EN to insert the Haraka v2 512-bit MIX
// step after every round (LANES must be 4 in that build).
module haraka_round_sched #(
    parameter int LANES         = 4,
    parameter int NUM_ROUNDS    = 5,
    parameter int AES_PER_ROUND = 2,
    parameter int RC_IDX_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [LANES*128-1:0]  start_data,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [LANES*128-1:0]  done_data,
    output logic                  busy,
    output logic [127:0]          aes_in,
    output logic                  aes_encrypt,
    output logic [RC_IDX_W-1:0]   rc_idx,
    input  logic [127:0]          rc_data,
    input  logic [127:0]          aes_out
);

    localparam int LW = $clog2(LANES);
    localparam int AW = (AES_PER_ROUND > 1) ? $clog2(AES_PER_ROUND) : 1;
    localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
`ifdef HARAKA_SCHED_MIX_EN
        S_MIX,
`endif
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // issue counters: lane (fastest), AES step, round (slowest)
    logic [LW-1:0] l_q, l_d;
    logic [AW-1:0] a_q, a_d;
    logic [RW-1:0] r_q, r_d;

    logic load_en;
    logic issue_en;
`ifdef HARAKA_SCHED_MIX_EN
    logic mix_en;
`endif

    // capture pipeline: tracks the issue made last cycle
    logic          cap_vld_q;
    logic [LW-1:0] cap_lane_q;
    logic [RC_IDX_W-1:0] rc_idx_q;
    logic [127:0]  aes_hold_q;

    logic [127:0] lane_vec [LANES];
    logic [RC_IDX_W-1:0] issue_idx;

    logic last_l, last_a, last_r;

    // rc_data feeds the AES unit directly; it is not used inside the sequencer
    logic rc_data_unused;
    assign rc_data_unused = ^rc_data;

    assign last_l = (l_q == LW'(LANES - 1));
    assign last_a = (a_q == AW'(AES_PER_ROUND - 1));
    assign last_r = (r_q == RW'(NUM_ROUNDS - 1));

    assign issue_idx = RC_IDX_W'((int'(r_q) * AES_PER_ROUND + int'(a_q)) * LANES + int'(l_q));

    // state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            a_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            a_q     <= a_d;
            r_q     <= r_d;
        end
    end

    // next-state, counter advance and per-state control strobes
    always_comb begin
        state_d  = state_q;
        l_d      = l_q;
        a_d      = a_q;
        r_d      = r_q;
        load_en  = 1'b0;
        issue_en = 1'b0;
`ifdef HARAKA_SCHED_MIX_EN
        mix_en   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    load_en = 1'b1;
                    l_d     = '0;
                    a_d     = '0;
                    r_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                issue_en = 1'b1;
                if (last_l) begin
                    l_d = '0;
                    if (last_a) begin
                        a_d = '0;
                        // r wraps to 0 after the final round; MIX uses that to finish
                        r_d = last_r ? '0 : r_q + RW'(1);
`ifdef HARAKA_SCHED_MIX_EN
                        state_d = S_DRAIN;
`else
                        if (last_r) begin
                            state_d = S_DRAIN;
                        end
`endif
                    end else begin
                        a_d = a_q + AW'(1);
                    end
                end else begin
                    l_d = l_q + LW'(1);
                end
            end
            S_DRAIN: begin
`ifdef HARAKA_SCHED_MIX_EN
                state_d = S_MIX;
`else
                state_d = S_DONE;
`endif
            end
`ifdef HARAKA_SCHED_MIX_EN
            S_MIX: begin
                mix_en  = 1'b1;
                state_d = (r_q == '0) ? S_DONE : S_ISSUE;
            end
`endif
            S_DONE: begin
                if (done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // remember the in-flight issue so its result lands in the right lane next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_q  <= 1'b0;
            cap_lane_q <= '0;
            rc_idx_q   <= '0;
            aes_hold_q <= '0;
        end else begin
            cap_vld_q  <= issue_en;
            cap_lane_q <= l_q;
            rc_idx_q   <= issue_en ? issue_idx : '0;
            if (issue_en) begin
                aes_hold_q <= lane_vec[l_q];
            end
        end
    end

`ifdef HARAKA_SCHED_MIX_EN
    logic [127:0] mix_vec [LANES];

    // Haraka v2 512-bit MIX: 32-bit word permutation across the four lanes
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mix_vec[i] = lane_vec[i];
        end
        mix_vec[0] = {lane_vec[3][127:96], lane_vec[1][127:96], lane_vec[2][127:96], lane_vec[0][127:96]};
        mix_vec[1] = {lane_vec[1][31:0],   lane_vec[3][31:0],   lane_vec[0][31:0],   lane_vec[2][31:0]};
        mix_vec[2] = {lane_vec[1][63:32],  lane_vec[3][63:32],  lane_vec[0][63:32],  lane_vec[2][63:32]};
        mix_vec[3] = {lane_vec[3][95:64],  lane_vec[1][95:64],  lane_vec[2][95:64],  lane_vec[0][95:64]};
    end
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [127:0] lane_q;

        // lane register: load on accept, overwrite with AES result on capture
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else if (load_en) begin
                lane_q <= start_data[128*gi +: 128];
            end else if (cap_vld_q && (cap_lane_q == LW'(gi))) begin
                lane_q <= aes_out;
`ifdef HARAKA_SCHED_MIX_EN
            end else if (mix_en) begin
                lane_q <= mix_vec[gi];
`endif
            end
        end

        assign lane_vec[gi]               = lane_q;
        assign done_data[128*gi +: 128]   = lane_q;
    end

    assign start_ready = (state_q == S_IDLE);
    assign done_valid  = (state_q == S_DONE);
    assign busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN)
`ifdef HARAKA_SCHED_MIX_EN
                       || (state_q == S_MIX)
`endif
                       ;
    // aes_in follows the issuing lane directly so the AES input register sees it this cycle
    assign aes_in      = issue_en ? lane_vec[l_q] : aes_hold_q;
    assign aes_encrypt = ~rst;
    assign rc_idx      = rc_idx_q;

endmodule

// File: tb/tb_haraka_round_sched.sv
// Testbench for haraka_round_sched: identity+XOR-rc AES model, rc ROM = rc_idx,
// scoreboard of expected results checked by a decoupled output monitor.
module tb_haraka_round_sched;

    localparam int L  = 4;
    localparam int NR = 5;
    localparam int AP = 2;
    localparam int RW = 6;
    localparam int W  = L * 128;
`ifdef HARAKA_SCHED_MIX_EN
    localparam int DONE_CYC = NR * (L * AP + 2) + 1;
`else
    localparam int DONE_CYC = NR * AP * L + 2;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic [W-1:0]   start_data;
    logic           done_valid;
    logic           done_ready;
    logic [W-1:0]   done_data;
    logic           busy;
    logic [127:0]   aes_in;
    logic           aes_encrypt;
    logic [RW-1:0]  rc_idx;
    logic [127:0]   rc_data;
    logic [127:0]   aes_out;
    logic [127:0]   aes_reg = '0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int txn = 0;
    int res_n = 0;
    int last_hs_cyc = -100;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    haraka_round_sched #(
        .LANES(L), .NUM_ROUNDS(NR), .AES_PER_ROUND(AP), .RC_IDX_W(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_data(start_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_data(done_data),
        .busy(busy), .aes_in(aes_in), .aes_encrypt(aes_encrypt),
        .rc_idx(rc_idx), .rc_data(rc_data), .aes_out(aes_out)
    );

    // AES unit model: input register, then XOR with the round constant
    always @(posedge clk) aes_reg <= aes_in;
    assign rc_data = 128'(rc_idx);
    assign aes_out = aes_reg ^ rc_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] unlo(input logic [127:0] x, input logic [127:0] y);
        return {y[63:32], x[63:32], y[31:0], x[31:0]};
    endfunction

    function automatic logic [127:0] unhi(input logic [127:0] x, input logic [127:0] y);
        return {y[127:96], x[127:96], y[95:64], x[95:64]};
    endfunction

    // Haraka v2 MIX written as the reference unpack sequence
    function automatic logic [W-1:0] mix512(input logic [W-1:0] s);
        logic [127:0] s0, s1, s2, s3, t;
        s0 = s[127:0]; s1 = s[255:128]; s2 = s[383:256]; s3 = s[511:384];
        t  = unlo(s0, s1);
        s0 = unhi(s0, s1);
        s1 = unlo(s2, s3);
        s2 = unhi(s2, s3);
        s3 = unlo(s0, s2);
        s0 = unhi(s0, s2);
        s2 = unhi(s1, t);
        s1 = unlo(s1, t);
        return {s3, s2, s1, s0};
    endfunction

    // reference permutation: each AES round of lane l adds constant (r*AP+a)*L+l
    function automatic logic [W-1:0] golden(input logic [W-1:0] s);
        logic [W-1:0] st;
        st = s;
        for (int r = 0; r < NR; r++) begin
            for (int a = 0; a < AP; a++) begin
                for (int l = 0; l < L; l++) begin
                    st[128*l +: 128] = st[128*l +: 128] ^ 128'((r * AP + a) * L + l);
                end
            end
`ifdef HARAKA_SCHED_MIX_EN
            st = mix512(st);
`endif
        end
        return st;
    endfunction

    // rc index expected in run cycle k (accept edge ends cycle 0)
    function automatic int exp_rc(input int k);
        int p;
        p = k - 2;
        if (p < 0) return 0;
`ifdef HARAKA_SCHED_MIX_EN
        if ((p % (L * AP + 2)) < L * AP) return (p / (L * AP + 2)) * L * AP + (p % (L * AP + 2));
        return 0;
`else
        if (p < NR * AP * L) return p;
        return 0;
`endif
    endfunction

    function automatic logic [W-1:0] rand_state();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // monitor: timing of rc_idx/busy/done_valid, and scoreboard on result handshake
    bit active = 1'b0;
    bit prev_dv = 1'b0;
    int acc_cyc = 0;
    always @(negedge clk) begin
        int k;
        if (rst) begin
            active  = 1'b0;
            prev_dv = 1'b0;
        end else begin
            if (active) begin
                k = cyc - acc_cyc;
                if (k >= 1 && k < DONE_CYC) begin
                    check("rc_idx", W'(rc_idx), W'(exp_rc(k)));
                    check("busy_run", W'(busy), W'(1));
                end
                if (done_valid && !prev_dv) check("done_rise_cycle", W'(k), W'(DONE_CYC));
            end
            if (done_valid && done_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got done handshake, expected none pending");
                end else begin
                    res_n++;
                    check("done_data", done_data, exp_q.pop_front());
                    $display("result %0d taken at cycle %0d", res_n, cyc);
                end
                last_hs_cyc = cyc;
                active = 1'b0;
            end
            if (start_valid && start_ready) begin
                acc_cyc = cyc;
                active  = 1'b1;
            end
            prev_dv = done_valid;
        end
    end

    // call at posedge+#1; returns at posedge+#1 just after the accept edge
    task automatic send(input logic [W-1:0] d, input bit b2b);
        int n;
        start_data  = d;
        start_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start_ready && n < 300);
        if (!start_ready) begin
            check("accept_timeout", W'(start_ready), W'(1));
            start_valid = 1'b0;
            return;
        end
        if (b2b) check("b2b_accept_cycle", W'(cyc), W'(last_hs_cyc + 1));
        exp_q.push_back(golden(d));
        txn++;
        $display("txn %0d accepted at cycle %0d", txn, cyc);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_dv(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_valid && n < bound);
        if (!done_valid) check("done_timeout", W'(done_valid), W'(1));
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", W'(exp_q.size()), W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, W'(start_ready), W'(1));
        check({tag, "_done_valid"}, W'(done_valid), W'(0));
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_rc_idx"}, W'(rc_idx), W'(0));
        check({tag, "_aes_in"}, W'(aes_in), W'(0));
    endtask

    initial begin
        logic [W-1:0] d;
        rst = 1'b1;
        start_valid = 1'b0;
        done_ready = 1'b0;
        start_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_aes_encrypt", W'(aes_encrypt), W'(0));
        check_reset_outputs("rst");
        rst = 1'b0;
        @(negedge clk);
        check("rel_aes_encrypt", W'(aes_encrypt), W'(1));
        check_reset_outputs("rel");

        // lane i = i, result held for 10 cycles with a stray start pulse
        @(posedge clk);
        #1;
        for (int i = 0; i < L; i++) d[128*i +: 128] = 128'(i);
        send(d, 1'b0);
        wait_dv(200);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (exp_q.size() != 0) check("hold_data", done_data, exp_q[0]);
            check("hold_done_valid", W'(done_valid), W'(1));
            check("hold_start_ready", W'(start_ready), W'(0));
            @(posedge clk);
            #1;
            start_valid = (i == 4);
            start_data  = rand_state();
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_start_ready", W'(start_ready), W'(1));
        check("idle_done_valid", W'(done_valid), W'(0));
        check("stray_start_dropped", W'(exp_q.size()), W'(0));

        // back-to-back: start_valid stays high across two states
        @(posedge clk);
        #1;
        send(rand_state(), 1'b0);
        send(rand_state(), 1'b1);
        wait_empty(300);

        // reset in cycle 20 of a run
        @(posedge clk);
        #1;
        send(rand_state(), 1'b0);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_aes_encrypt", W'(aes_encrypt), W'(0));
        check_reset_outputs("midrst");
        $display("txn %0d discarded by reset at cycle %0d", txn, cyc);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(rand_state(), 1'b0);
        wait_empty(300);

        // all-zero state and a few random ones, with random result back-pressure
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            done_ready = 1'b0;
            send((t == 0) ? '0 : rand_state(), 1'b0);
            repeat (DONE_CYC + $urandom_range(0, 5)) @(posedge clk);
            #1;
            done_ready = 1'b1;
            wait_empty(300);
        end

        check("queue_empty_at_end", W'(exp_q.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/haraka_round_sched.md
Name: haraka_round_sched

Overview:
- Sequencer that time-shares one single-round AES unit across the LANES 128-bit lanes of a Haraka state.
- Accepts a full LANES*128-bit state over a valid/ready handshake and iterates NUM_ROUNDS x AES_PER_ROUND AES rounds per lane.
- Supplies the AES unit's input, encrypt select and round-constant index, writes results back into the lane registers, and returns the permuted state over a second valid/ready handshake.
- The AES unit has exactly 1 cycle of latency: input is registered after SubBytes; ShiftRows, MixColumns and AddRoundConstant are combinational after that register.

Parameters:
- LANES, 4, number of 128-bit lanes; must be >= 2.
- NUM_ROUNDS, 5, Haraka rounds.
- AES_PER_ROUND, 2, AES rounds per lane per Haraka round.
- RC_IDX_W, 6, width of rc_idx; must be >= clog2(NUM_ROUNDS*AES_PER_ROUND*LANES).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  input state offered.
- start_ready  output  1  scheduler can accept a state.
- start_data  input  LANES*128  input state; lane i is bits [128*i+127:128*i].
- done_valid  output  1  result state available.
- done_ready  input  1  consumer accepts the result.
- done_data  output  LANES*128  result state, same lane packing as start_data.
- busy  output  1  high in ISSUE, DRAIN and MIX.
- aes_in  output  128  AES unit input (lane being issued).
- aes_encrypt  output  1  AES unit direction; constant 1 outside reset.
- rc_idx  output  RC_IDX_W  round-constant ROM index for the result arriving this cycle.
- rc_data  input  128  ROM output; combinational from rc_idx, driven to the AES unit's round-constant input.
- aes_out  input  128  AES unit output.

Behaviour:
- Reset (async, any state): state=IDLE; lane registers, counters, rc_idx, aes_in = 0; start_ready=1; done_valid=0; busy=0; aes_encrypt=0 while rst is high, 1 after.
- States: IDLE, ISSUE, DRAIN, MIX (MIX only with the macro defined), DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready, load all lanes, clear counters (round r, aes step a, lane l), go to ISSUE.
- ISSUE, cycle c:
  - aes_in = lane[l].
  - Advance the counters in order l, then a, then r.
- Capture:
  - An issue made in cycle c is captured into lane[l] at the end of cycle c+1 from aes_out.
  - During cycle c+1, rc_idx = (r*AES_PER_ROUND + a)*LANES + l of that issue.
  - Issue and capture of different lanes overlap every cycle. LANES>=2 guarantees a lane is captured before it is reissued.
- Leaving ISSUE:
  - After the last issue of the final (r,a,l), go to DRAIN.
  - Last capture happens in DRAIN; then go to DONE.
- Latency with defaults: accept edge ends cycle 0; ISSUE in cycles 1..40; DRAIN in cycle 41; done_valid=1 from cycle 42.
- DONE:
  - done_valid=1 and done_data = lane registers, held stable until done_ready.
  - On done_valid&done_ready go to IDLE.
  - start_ready=0 in every state except IDLE; no new state is accepted in the same cycle a result is taken.
- aes_in holds its last value outside ISSUE. rc_idx = 0 outside capture cycles.
- start_valid outside IDLE is ignored; start_data is sampled only at the accept edge.
- rst asserted mid-run discards the run; no partial result is produced.

Optional Feature:
- Macro: HARAKA_SCHED_MIX_EN.
- Defined:
  - After the last issue of each round (a=AES_PER_ROUND-1, l=LANES-1), go to DRAIN, then MIX, then the next round's ISSUE, or DONE after the final round.
  - MIX applies the Haraka v2 512-bit MIX (32-bit word permutation across the 4 lanes) to all lane registers in one cycle. Requires LANES=4.
  - Default latency: 5*(8+2)=50 busy cycles; done_valid from cycle 51.
- Undefined: no MIX state; lanes are only AES-round transformed; done_valid from cycle 42.

Test Plan:
- Reset, then release: start_ready=1, done_valid=0, busy=0, rc_idx=0, aes_in=0.
- Accept a state with start_data lane i = i; bench AES model = identity with XOR of rc_data; rc ROM returns {rc_idx}.
  - rc_idx sequence is 0..39, one per cycle, cycles 2..41.
  - done_valid rises at cycle 42.
  - done_data matches the golden model.
- done_ready held low 10 cycles after done_valid: done_data stable, start_ready=0, a start_valid pulse is ignored. Then done_ready=1 -> IDLE next cycle.
- Back-to-back: start_valid held high across two states -> second accept occurs the cycle after the first result handshake; both results correct.
- rst pulsed at cycle 20 of a run -> all outputs return to reset values immediately; the next start produces a correct result with no residue.
- HARAKA_SCHED_MIX_EN defined, all-zero input, real AES model and Haraka-512 constants -> done_valid at cycle 51; done_data equals the reference Haraka-512 permutation output (before feed-forward).
